// File: rtl/sobel_window_3x3_pkg.sv
// sobel_window_3x3_pkg
//   Shared camera-path constants: the default pixel width and QVGA frame
//   geometry, plus the helper that sizes the column and row counters.
//   The same values are used by edge_sobel and the VGA stage.
package sobel_window_3x3_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_IMG_WIDTH  = 320;
  localparam int DEF_IMG_HEIGHT = 240;

  // Counter width for n positions; never narrower than 1 bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sobel_window_3x3_line_buffer.sv
// sobel_window_3x3_line_buffer
//   One image line of pixel storage (DATA_WIDTH x DEPTH), single clock.
//   The shared address is read combinationally and written on the rising
//   edge, so a read in the write cycle returns the old contents. The
//   contents are never reset.
// Ports
//   pclk_i   in   pixel clock
//   wr_en    in   write strobe
//   addr     in   read/write address (column)
//   wr_data  in   data written at addr
//   rd_data  out  current contents at addr
module sobel_window_3x3_line_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 320,
  parameter int ADDR_W     = 9
) (
  input  logic                  pclk_i,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge pclk_i) begin
    if (wr_en) mem[addr] <= wr_data;
  end

  assign rd_data = mem[addr];

endmodule

// File: rtl/sobel_window_3x3.sv
// sobel_window_3x3
//   Builds a 3x3 pixel neighbourhood from the raster stream for edge_sobel.
//   Two line buffers hold rows r-1 (lb0) and r-2 (lb1); three column shift
//   registers form the window. Pixels entering from rows/columns outside the
//   image are zero-filled. Window and syncs are 1 clk behind the input.
// Configuration
//   WIN_VALID_EN  adds win_valid_o, high when the emitted window lies fully
//                 inside the image (row >= 2 and col >= 2).
// Ports
//   pclk_i              in   pixel clock
//   rstn_i              in   async active-low reset
//   fsync_i / rsync_i   in   frame / line active
//   pData_i             in   pixel, accepted when fsync_i & rsync_i
//   fsync_o / rsync_o   out  syncs delayed 1 clk
//   win_valid_o         out  (WIN_VALID_EN only) window fully inside image
//   pData1_o..pData9_o  out  window, row-major, pData9_o = newest pixel
module sobel_window_3x3
  import sobel_window_3x3_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
  input  logic                  pclk_i,
  input  logic                  rstn_i,
  input  logic                  fsync_i,
  input  logic                  rsync_i,
  input  logic [DATA_WIDTH-1:0] pData_i,
  output logic                  fsync_o,
  output logic                  rsync_o,
`ifdef WIN_VALID_EN
  output logic                  win_valid_o,
`endif
  output logic [DATA_WIDTH-1:0] pData1_o,
  output logic [DATA_WIDTH-1:0] pData2_o,
  output logic [DATA_WIDTH-1:0] pData3_o,
  output logic [DATA_WIDTH-1:0] pData4_o,
  output logic [DATA_WIDTH-1:0] pData5_o,
  output logic [DATA_WIDTH-1:0] pData6_o,
  output logic [DATA_WIDTH-1:0] pData7_o,
  output logic [DATA_WIDTH-1:0] pData8_o,
  output logic [DATA_WIDTH-1:0] pData9_o
);

  localparam int COL_W = idx_w(IMG_WIDTH);
  localparam int ROW_W = idx_w(IMG_HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  logic                  vld;
  logic                  rsync_fall;
  logic [COL_W-1:0]      col;
  logic [ROW_W-1:0]      row;
  // Set once the last buffer column has been written in this line; extra
  // pixels of an over-long line must not overwrite it (or shift lb1 twice).
  logic                  line_full;
  logic [DATA_WIDTH-1:0] lb0_rd, lb1_rd;
  logic [DATA_WIDTH-1:0] top_in, mid_in;
  logic                  left_edge;

  assign vld        = fsync_i & rsync_i;
  assign rsync_fall = rsync_o & ~rsync_i;
  assign left_edge  = (col == '0);
  assign top_in     = (row == '0 || row == ROW_W'(1)) ? '0 : lb1_rd;
  assign mid_in     = (row == '0) ? '0 : lb0_rd;

  sobel_window_3x3_line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (IMG_WIDTH),
    .ADDR_W     (COL_W)
  ) u_lb0 (
    .pclk_i  (pclk_i),
    .wr_en   (vld & ~line_full),
    .addr    (col),
    .wr_data (pData_i),
    .rd_data (lb0_rd)
  );

  sobel_window_3x3_line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (IMG_WIDTH),
    .ADDR_W     (COL_W)
  ) u_lb1 (
    .pclk_i  (pclk_i),
    .wr_en   (vld & ~line_full),
    .addr    (col),
    .wr_data (lb0_rd),
    .rd_data (lb1_rd)
  );

  always_ff @(posedge pclk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      fsync_o   <= 1'b0;
      rsync_o   <= 1'b0;
      col       <= '0;
      row       <= '0;
      line_full <= 1'b0;
    end else begin
      fsync_o <= fsync_i;
      rsync_o <= rsync_i;
      if (!fsync_i) begin
        col       <= '0;
        row       <= '0;
        line_full <= 1'b0;
      end else if (rsync_fall) begin
        col       <= '0;
        line_full <= 1'b0;
        if (row != ROW_LAST) row <= row + 1'b1;
      end else if (vld) begin
        if (col == COL_LAST) line_full <= 1'b1;
        else                 col       <= col + 1'b1;
      end
    end
  end

  always_ff @(posedge pclk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pData1_o <= '0; pData2_o <= '0; pData3_o <= '0;
      pData4_o <= '0; pData5_o <= '0; pData6_o <= '0;
      pData7_o <= '0; pData8_o <= '0; pData9_o <= '0;
    end else if (vld) begin
      pData3_o <= top_in;
      pData6_o <= mid_in;
      pData9_o <= pData_i;
      // First pixel of a line: drop whatever the previous line left behind.
      if (left_edge) begin
        pData1_o <= '0; pData2_o <= '0;
        pData4_o <= '0; pData5_o <= '0;
        pData7_o <= '0; pData8_o <= '0;
      end else begin
        pData1_o <= pData2_o; pData2_o <= pData3_o;
        pData4_o <= pData5_o; pData5_o <= pData6_o;
        pData7_o <= pData8_o; pData8_o <= pData9_o;
      end
    end
  end

`ifdef WIN_VALID_EN
  always_ff @(posedge pclk_i or negedge rstn_i) begin
    if (!rstn_i) win_valid_o <= 1'b0;
    else         win_valid_o <= vld && (row >= ROW_W'(2)) && (col >= COL_W'(2));
  end
`endif

endmodule
